// File: rtl/color_face_capture_pkg.sv
// Shared colour-detect definitions: colour codes, face geometry and the
// capture FSM encoding.
package color_face_capture_pkg;

    localparam logic [2:0] COLOR_RED      = 3'd0;
    localparam logic [2:0] COLOR_ORANGE   = 3'd1;
    localparam logic [2:0] COLOR_YELLOW   = 3'd2;
    localparam logic [2:0] COLOR_GREEN    = 3'd3;
    localparam logic [2:0] COLOR_BLUE     = 3'd4;
    localparam logic [2:0] COLOR_WHITE    = 3'd5;
    localparam logic [2:0] COLOR_UNKNOWN6 = 3'd6;
    localparam logic [2:0] COLOR_UNKNOWN7 = 3'd7;

    localparam int NUM_FACES = 6;
    localparam int FACELETS  = 9;
    localparam int FACE_W    = 3 * FACELETS;
    localparam int CENTER    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_STORE = 2'd2
    } state_t;

    function automatic logic is_unknown(input logic [2:0] c);
        return (c == COLOR_UNKNOWN6) || (c == COLOR_UNKNOWN7);
    endfunction

endpackage

// File: rtl/color_face_capture_stability.sv
// Snapshot compare with saturating stable and frame counters; the next-count
// values are exported so the FSM can decide on the same update edge.
module face_stability_counter
    import color_face_capture_pkg::*;
#(
    parameter int STABLE_W  = 4,
    parameter int TIMEOUT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 update,
    input  logic [FACE_W-1:0]    colors,
    output logic [FACE_W-1:0]    snapshot,
    output logic [STABLE_W-1:0]  stable_nxt,
    output logic [TIMEOUT_W-1:0] frame_nxt
);

    logic [STABLE_W-1:0]  stable_cnt;
    logic [TIMEOUT_W-1:0] frame_cnt;
    logic [FACE_W-1:0]    snap_nxt;
    logic                 any_unknown;

    always_comb begin
        any_unknown = 1'b0;
        for (int k = 0; k < FACELETS; k++) begin
            if (is_unknown(colors[3*k +: 3])) any_unknown = 1'b1;
        end
    end

    always_comb begin
        stable_nxt = stable_cnt;
        frame_nxt  = frame_cnt;
        snap_nxt   = snapshot;
        if (update) begin
            frame_nxt = (&frame_cnt) ? frame_cnt : frame_cnt + TIMEOUT_W'(1);
            if (any_unknown) begin
                stable_nxt = '0;
            end else if (colors == snapshot) begin
                stable_nxt = (&stable_cnt) ? stable_cnt : stable_cnt + STABLE_W'(1);
            end else begin
                snap_nxt   = colors;
                stable_nxt = STABLE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_cnt <= '0;
            frame_cnt  <= '0;
            snapshot   <= '0;
        end else if (clear) begin
            stable_cnt <= '0;
            frame_cnt  <= '0;
            snapshot   <= '0;
        end else begin
            stable_cnt <= stable_nxt;
            frame_cnt  <= frame_nxt;
            snapshot   <= snap_nxt;
        end
    end

endmodule

// File: rtl/color_face_capture.sv
// Captures a stable 3x3 facelet colour frame into a six-entry face store,
// indexed by the centre facelet colour.
module color_face_capture
    import color_face_capture_pkg::*;
#(
    parameter int STABLE_W  = 4,
    parameter int TIMEOUT_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic [2:0]           i_color0,
    input  logic [2:0]           i_color1,
    input  logic [2:0]           i_color2,
    input  logic [2:0]           i_color3,
    input  logic [2:0]           i_color4,
    input  logic [2:0]           i_color5,
    input  logic [2:0]           i_color6,
    input  logic [2:0]           i_color7,
    input  logic [2:0]           i_color8,
    input  logic                 i_update,
    input  logic                 i_capture_req,
    input  logic                 i_clear,
    input  logic [STABLE_W-1:0]  i_stable_frames,
    input  logic [TIMEOUT_W-1:0] i_timeout_frames,
    input  logic [2:0]           i_rd_face,
    output logic [FACE_W-1:0]    o_rd_data,
    output logic                 o_busy,
    output logic                 o_face_done,
    output logic [2:0]           o_face_idx,
    output logic                 o_overwrite,
    output logic                 o_timeout,
    output logic [5:0]           o_valid_mask,
    output logic                 o_all_valid
);

    state_t               state;
    logic [FACE_W-1:0]    colors;
    logic [FACE_W-1:0]    snapshot;
    logic [STABLE_W-1:0]  stable_nxt;
    logic [STABLE_W-1:0]  stable_thr;
    logic [TIMEOUT_W-1:0] frame_nxt;
    logic [2:0]           store_idx;
    logic                 start;
    logic                 upd;
    logic                 stable_hit;
    logic                 timeout_hit;
    logic                 do_write;
    logic [FACE_W-1:0]    face_mem [NUM_FACES];

    assign colors = {i_color8, i_color7, i_color6, i_color5, i_color4,
                     i_color3, i_color2, i_color1, i_color0};

    assign start = (state == ST_IDLE)  && i_capture_req && !i_clear;
    assign upd   = (state == ST_ARMED) && i_update      && !i_clear;

    face_stability_counter #(
        .STABLE_W  (STABLE_W),
        .TIMEOUT_W (TIMEOUT_W)
    ) u_stability (
        .clk        (i_clk),
        .rst_n      (i_rstn),
        .clear      (start),
        .update     (upd),
        .colors     (colors),
        .snapshot   (snapshot),
        .stable_nxt (stable_nxt),
        .frame_nxt  (frame_nxt)
    );

    assign stable_thr  = (i_stable_frames == '0) ? STABLE_W'(1) : i_stable_frames;
    assign stable_hit  = stable_nxt >= stable_thr;
    assign timeout_hit = (i_timeout_frames != '0) && (frame_nxt >= i_timeout_frames);
    assign store_idx   = snapshot[3*CENTER +: 3];
    assign do_write    = (state == ST_STORE) && !i_clear && (store_idx < 3'(NUM_FACES));

    assign o_busy      = (state != ST_IDLE);
    assign o_all_valid = &o_valid_mask;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state        <= ST_IDLE;
            o_face_done  <= 1'b0;
            o_face_idx   <= '0;
            o_overwrite  <= 1'b0;
            o_timeout    <= 1'b0;
            o_valid_mask <= '0;
        end else begin
            o_face_done <= 1'b0;
            o_overwrite <= 1'b0;
            o_timeout   <= 1'b0;
            if (i_clear) begin
                state        <= ST_IDLE;
                o_valid_mask <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (i_capture_req) state <= ST_ARMED;
                    end
                    ST_ARMED: begin
                        // Stability is tested first so it wins a same-edge timeout.
                        if (i_update) begin
                            if (stable_hit) begin
                                state <= ST_STORE;
                            end else if (timeout_hit) begin
                                state     <= ST_IDLE;
                                o_timeout <= 1'b1;
                            end
                        end
                    end
                    ST_STORE: begin
                        state <= ST_IDLE;
                        if (do_write) begin
                            o_face_done             <= 1'b1;
                            o_face_idx              <= store_idx;
                            o_overwrite             <= o_valid_mask[store_idx];
                            o_valid_mask[store_idx] <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < NUM_FACES; i++) face_mem[i] <= '0;
        end else if (do_write) begin
            face_mem[store_idx] <= snapshot;
        end
    end

    // A read of the face being written this cycle returns the new data.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_rd_data <= '0;
        end else if (i_rd_face < 3'(NUM_FACES)) begin
            o_rd_data <= (do_write && (i_rd_face == store_idx)) ? snapshot
                                                               : face_mem[i_rd_face];
        end else begin
            o_rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_color_face_capture.sv
// Directed bench for color_face_capture: table-driven six-face capture plus
// hand-written sequences for stability, timeout, overwrite, clear and reset.
module tb_color_face_capture;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic [2:0]  i_color0 = '0, i_color1 = '0, i_color2 = '0, i_color3 = '0, i_color4 = '0;
    logic [2:0]  i_color5 = '0, i_color6 = '0, i_color7 = '0, i_color8 = '0;
    logic        i_update = 1'b0;
    logic        i_capture_req = 1'b0;
    logic        i_clear = 1'b0;
    logic [3:0]  i_stable_frames = 4'd3;
    logic [7:0]  i_timeout_frames = 8'd0;
    logic [2:0]  i_rd_face = 3'd0;
    logic [26:0] o_rd_data;
    logic        o_busy, o_face_done, o_overwrite, o_timeout, o_all_valid;
    logic [2:0]  o_face_idx;
    logic [5:0]  o_valid_mask;

    int n_checks = 0;
    int n_fail   = 0;

    color_face_capture #(.STABLE_W(4), .TIMEOUT_W(8)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_color0(i_color0), .i_color1(i_color1), .i_color2(i_color2),
        .i_color3(i_color3), .i_color4(i_color4), .i_color5(i_color5),
        .i_color6(i_color6), .i_color7(i_color7), .i_color8(i_color8),
        .i_update(i_update), .i_capture_req(i_capture_req), .i_clear(i_clear),
        .i_stable_frames(i_stable_frames), .i_timeout_frames(i_timeout_frames),
        .i_rd_face(i_rd_face), .o_rd_data(o_rd_data), .o_busy(o_busy),
        .o_face_done(o_face_done), .o_face_idx(o_face_idx), .o_overwrite(o_overwrite),
        .o_timeout(o_timeout), .o_valid_mask(o_valid_mask), .o_all_valid(o_all_valid)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0]  sf;
        logic [26:0] face;
        logic [2:0]  exp_idx;
        logic        exp_ovr;
        logic [5:0]  exp_mask;
        logic        exp_all;
    } vec_t;

    vec_t tbl [6];

    function automatic logic [26:0] mk(input logic [2:0] fill, input logic [2:0] center);
        logic [26:0] f;
        f = {9{fill}};
        f[14:12] = center;
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_colors(input logic [26:0] f);
        i_color0 = f[2:0];   i_color1 = f[5:3];   i_color2 = f[8:6];
        i_color3 = f[11:9];  i_color4 = f[14:12]; i_color5 = f[17:15];
        i_color6 = f[20:18]; i_color7 = f[23:21]; i_color8 = f[26:24];
    endtask

    task automatic upd(input logic [26:0] f);
        set_colors(f);
        i_update = 1'b1;
        tick();
        i_update = 1'b0;
    endtask

    task automatic req();
        i_capture_req = 1'b1;
        tick();
        i_capture_req = 1'b0;
    endtask

    logic [26:0] fa, fx, fy, fz, fz7, fb, fd;

    initial begin
        fa = mk(3'd1, 3'd2);
        fx = mk(3'd3, 3'd1);
        fy = mk(3'd4, 3'd1);
        fz = mk(3'd0, 3'd3);
        fz7 = fz; fz7[2:0] = 3'd7;
        fb = mk(3'd1, 3'd4);
        fd = mk(3'd5, 3'd2);

        tbl[0] = '{4'd1, mk(3'd2, 3'd0), 3'd0, 1'b0, 6'b000001, 1'b0};
        tbl[1] = '{4'd2, mk(3'd3, 3'd1), 3'd1, 1'b0, 6'b000011, 1'b0};
        tbl[2] = '{4'd0, mk(3'd4, 3'd2), 3'd2, 1'b0, 6'b000111, 1'b0};
        tbl[3] = '{4'd3, mk(3'd5, 3'd3), 3'd3, 1'b0, 6'b001111, 1'b0};
        tbl[4] = '{4'd1, mk(3'd0, 3'd4), 3'd4, 1'b0, 6'b011111, 1'b0};
        tbl[5] = '{4'd2, mk(3'd1, 3'd5), 3'd5, 1'b0, 6'b111111, 1'b1};

        // Reset state
        #12;
        check("rst_busy", 32'(o_busy), 0);
        check("rst_mask", 32'(o_valid_mask), 0);
        check("rst_rd", 32'(o_rd_data), 0);
        check("rst_done", 32'(o_face_done), 0);
        check("rst_timeout", 32'(o_timeout), 0);
        tick();
        i_rstn = 1'b1;
        tick();

        // Three identical frames, plus a capture request ignored while armed
        i_stable_frames = 4'd3;
        req();
        check("armed_busy", 32'(o_busy), 1);
        upd(fa);
        req();
        upd(fa);
        upd(fa);
        check("s1_store_busy", 32'(o_busy), 1);
        check("s1_no_early_done", 32'(o_face_done), 0);
        tick();
        check("s1_done", 32'(o_face_done), 1);
        check("s1_idx", 32'(o_face_idx), 2);
        check("s1_mask", 32'(o_valid_mask), 32'h04);
        check("s1_ovr", 32'(o_overwrite), 0);
        check("s1_idle", 32'(o_busy), 0);
        tick();
        check("s1_done_pulse", 32'(o_face_done), 0);
        upd(fa);
        tick();
        check("idle_upd_ignored", 32'(o_busy), 0);

        // Colour change on the 2nd frame restarts the count
        req();
        upd(fx); upd(fy); upd(fy);
        tick();
        check("s2_not_yet", 32'(o_face_done), 0);
        check("s2_still_busy", 32'(o_busy), 1);
        upd(fy);
        tick();
        check("s2_done", 32'(o_face_done), 1);
        check("s2_idx", 32'(o_face_idx), 1);
        check("s2_mask", 32'(o_valid_mask), 32'h06);

        // Unknown facelet mid-run drops the count to zero
        req();
        upd(fz); upd(fz); upd(fz7); upd(fz); upd(fz);
        tick();
        check("s3_unknown_restart", 32'(o_face_done), 0);
        upd(fz);
        tick();
        check("s3_done", 32'(o_face_done), 1);
        check("s3_idx", 32'(o_face_idx), 3);
        check("s3_mask", 32'(o_valid_mask), 32'h0E);

        // Timeout with alternating frames
        i_timeout_frames = 8'd5;
        req();
        upd(mk(3'd0, 3'd4)); upd(fb); upd(mk(3'd0, 3'd4)); upd(fb);
        check("to_not_yet", 32'(o_timeout), 0);
        check("to_busy4", 32'(o_busy), 1);
        upd(mk(3'd0, 3'd4));
        check("to_pulse", 32'(o_timeout), 1);
        check("to_idle", 32'(o_busy), 0);
        check("to_mask", 32'(o_valid_mask), 32'h0E);
        tick();
        check("to_pulse_end", 32'(o_timeout), 0);
        check("to_no_done", 32'(o_face_done), 0);

        // Stability and timeout on the same update: stability wins
        i_stable_frames = 4'd2;
        i_timeout_frames = 8'd2;
        req();
        upd(fb); upd(fb);
        check("tie_no_timeout", 32'(o_timeout), 0);
        check("tie_store", 32'(o_busy), 1);
        tick();
        check("tie_done", 32'(o_face_done), 1);
        check("tie_idx", 32'(o_face_idx), 4);
        check("tie_mask", 32'(o_valid_mask), 32'h1E);
        i_timeout_frames = 8'd0;

        // Overwrite face 2 with stable threshold 0 (acts as 1), read bypass
        i_stable_frames = 4'd0;
        i_rd_face = 3'd2;
        tick();
        check("rd_old", o_rd_data, fa);
        req();
        upd(fd);
        check("rd_before_write", o_rd_data, fa);
        tick();
        check("ovr_done", 32'(o_face_done), 1);
        check("ovr_flag", 32'(o_overwrite), 1);
        check("ovr_idx", 32'(o_face_idx), 2);
        check("rd_bypass", o_rd_data, fd);
        i_rd_face = 3'd6;
        tick();
        check("rd_face6", o_rd_data, 0);
        i_rd_face = 3'd7;
        tick();
        check("rd_face7", o_rd_data, 0);

        // Clear in the STORE cycle
        i_stable_frames = 4'd1;
        req();
        upd(mk(3'd2, 3'd5));
        check("clr_in_store", 32'(o_busy), 1);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        check("clr_no_done", 32'(o_face_done), 0);
        check("clr_mask", 32'(o_valid_mask), 0);
        check("clr_idle", 32'(o_busy), 0);
        i_rd_face = 3'd5;
        tick();
        check("clr_no_write", o_rd_data, 0);
        i_rd_face = 3'd1;
        tick();
        check("clr_mem_kept", o_rd_data, fy);

        // Six faces from the table
        for (int i = 0; i < 6; i++) begin
            i_stable_frames = tbl[i].sf;
            req();
            for (int n = 0; n < ((tbl[i].sf == 0) ? 1 : int'(tbl[i].sf)); n++) upd(tbl[i].face);
            i_rd_face = tbl[i].exp_idx;
            tick();
            check($sformatf("tbl%0d_done", i), 32'(o_face_done), 1);
            check($sformatf("tbl%0d_idx", i), 32'(o_face_idx), 32'(tbl[i].exp_idx));
            check($sformatf("tbl%0d_ovr", i), 32'(o_overwrite), 32'(tbl[i].exp_ovr));
            check($sformatf("tbl%0d_mask", i), 32'(o_valid_mask), 32'(tbl[i].exp_mask));
            check($sformatf("tbl%0d_all", i), 32'(o_all_valid), 32'(tbl[i].exp_all));
            check($sformatf("tbl%0d_rd", i), o_rd_data, tbl[i].face);
        end

        // Reset while armed, then stray updates without a request
        i_stable_frames = 4'd3;
        i_rd_face = 3'd2;
        req();
        upd(fa);
        #2;
        i_rstn = 1'b0;
        #1;
        check("arst_busy", 32'(o_busy), 0);
        check("arst_mask", 32'(o_valid_mask), 0);
        check("arst_all", 32'(o_all_valid), 0);
        check("arst_rd", 32'(o_rd_data), 0);
        tick();
        i_rstn = 1'b1;
        upd(fa); upd(fa); upd(fa);
        tick();
        check("post_rst_idle", 32'(o_busy), 0);
        check("post_rst_no_done", 32'(o_face_done), 0);
        check("post_rst_mem", o_rd_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
